// File: rtl/two_bit_adder.sv
// Registered unsigned ripple-carry adder: {cout,sum} = a + b, one cycle of
// latency, one result per cycle. The sum is built from a chain of
// full-adder cells. Only the output stage holds state.

// One bit of the ripple chain: sum bit plus carry into the next stage.
module two_bit_adder_fa_cell (
   input  logic a,
   input  logic b,
   input  logic carry,
   output logic sum,
   output logic carry_next
);

   logic half_sum;

   // Propagate term (a^b) is shared by the sum and the carry logic
   assign half_sum   = a ^ b;
   assign sum        = half_sum ^ carry;
   assign carry_next = (a & b) | (carry & half_sum);

endmodule

// Top level: ripple chain feeding a single bank of output registers.
module two_bit_adder #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the adder carry-out
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;

   // The least significant stage has no carry-in
   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         two_bit_adder_fa_cell u_fa (
            .a          (a[gi]),
            .b          (b[gi]),
            .carry      (carry[gi]),
            .sum        (sum_next[gi]),
            .carry_next (carry[gi+1])
         );
      end
   endgenerate

   // Capture every cycle, regardless of in_valid, so the outputs track the
   // inputs; out_valid simply follows in_valid with the same latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         sum       <= sum_next;
         cout      <= carry[WIDTH];
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_two_bit_adder.sv
// Self-checking bench for two_bit_adder: a table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized run against an
// arithmetic reference model.
module tb_two_bit_adder;

   logic       clk;
   logic       rst;
   logic [1:0] a;
   logic [1:0] b;
   logic       in_valid;
   logic [1:0] sum;
   logic       cout;
   logic       out_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [1:0] a;
      logic [1:0] b;
      logic       v;
      logic [2:0] exp_res;   // {cout,sum}
      logic       exp_v;
   } vec_t;

   vec_t vecs[$];

   two_bit_adder #(.WIDTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer addition, carry is whether the total reaches 4
   function automatic logic [2:0] ref_add(input logic [1:0] x, input logic [1:0] y);
      int total;
      total = int'(x) + int'(y);
      return {(total >= 4) ? 1'b1 : 1'b0, 2'(total % 4)};
   endfunction

   task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got {cout,sum,valid}=%b expected %b", name, actual, expected);
      end else begin
         $display("ok   %s: {cout,sum,valid}=%b", name, actual);
      end
   endtask

   // Drive inputs, let one rising edge capture them, then sample 1 time unit later
   task automatic apply(input logic r, input logic [1:0] x, input logic [1:0] y, input logic v);
      rst = r; a = x; b = y; in_valid = v;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string n, input logic [1:0] x, input logic [1:0] y,
                               input logic v, input logic [2:0] e, input logic ev);
      vec_t t;
      t.name = n; t.a = x; t.b = y; t.v = v; t.exp_res = e; t.exp_v = ev;
      return t;
   endfunction

   initial begin
      logic [2:0] exp_res;
      logic       exp_v;
      logic       r;

      // Directed table: exhaustive sweep, then spec corner vectors
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            vecs.push_back(mk($sformatf("sweep %0d+%0d", i, j), 2'(i), 2'(j), 1'b1,
                              3'(i + j), 1'b1));
      vecs.push_back(mk("ex 1+1",        2'd1, 2'd1, 1'b1, 3'b0_10, 1'b1));
      vecs.push_back(mk("ex 2+3",        2'd2, 2'd3, 1'b1, 3'b1_01, 1'b1));
      vecs.push_back(mk("carry 1+3",     2'd1, 2'd3, 1'b1, 3'b1_00, 1'b1));
      vecs.push_back(mk("nocarry 1+2",   2'd1, 2'd2, 1'b1, 3'b0_11, 1'b1));
      vecs.push_back(mk("valid pulse 1", 2'd2, 2'd0, 1'b1, 3'b0_10, 1'b1));
      vecs.push_back(mk("valid pulse 0", 2'd0, 2'd3, 1'b0, 3'b0_11, 1'b0));
      vecs.push_back(mk("valid pulse 1", 2'd3, 2'd1, 1'b1, 3'b1_00, 1'b1));
      for (int k = 0; k < 4; k++) begin
         vecs.push_back(mk("b2b 3+3", 2'd3, 2'd3, 1'b1, 3'b1_10, 1'b1));
         vecs.push_back(mk("b2b 0+0", 2'd0, 2'd0, 1'b1, 3'b0_00, 1'b1));
      end

      // Reset held for two cycles with maximal operands
      for (int k = 0; k < 2; k++) begin
         apply(1'b1, 2'd3, 2'd3, 1'b1);
         check($sformatf("reset cycle %0d", k), {cout, sum, out_valid}, 4'b0);
      end

      foreach (vecs[i]) begin
         apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].v);
         check(vecs[i].name, {cout, sum, out_valid}, {vecs[i].exp_res, vecs[i].exp_v});
      end

      // Reset mid-stream discards the in-flight result; recovery is immediate
      apply(1'b0, 2'd3, 2'd2, 1'b1);
      check("midrst pre 3+2", {cout, sum, out_valid}, 4'b1_01_1);
      apply(1'b1, 2'd3, 2'd2, 1'b1);
      check("midrst asserted", {cout, sum, out_valid}, 4'b0);
      apply(1'b0, 2'd2, 2'd1, 1'b1);
      check("midrst recover 2+1", {cout, sum, out_valid}, 4'b0_11_1);

      // Randomized run with occasional resets
      for (int n = 0; n < 150; n++) begin
         logic [1:0] ra;
         logic [1:0] rb;
         logic       rv;
         ra = 2'($urandom_range(0, 3));
         rb = 2'($urandom_range(0, 3));
         rv = 1'($urandom_range(0, 1));
         r  = ($urandom_range(0, 15) == 0);
         if (r) begin
            exp_res = 3'b0;
            exp_v   = 1'b0;
         end else begin
            exp_res = ref_add(ra, rb);
            exp_v   = rv;
         end
         apply(r, ra, rb, rv);
         check($sformatf("rand %0d rst=%0b %0d+%0d v=%0b", n, r, ra, rb, rv),
               {cout, sum, out_valid}, {exp_res, exp_v});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
